ex_mem: RTL and testbench
=========================

# ex_mem

Pipeline register between the execute stage and the memory-access stage of the five-stage integer pipeline. Captures the execute stage's write-back request, HI/LO write request and load/store descriptor each cycle, and presents them to the memory-access stage. Honours the pipeline stall vector by holding or inserting a bubble, and clears on flush. Also carries the two-cycle multiply-accumulate partial product (`hilo_temp`) and cycle counter back to the execute stage across a stall.

## Interface

Parameters: none. Widths come from the shared `precompiled.v` defines: `RegBus`=32, `RegAddrBus`=5, `DoubleRegBus`=64, `AluOpBus`=8.

- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset (`RstEnable`=1)
- stall  in  6  stall vector; bit 3 = execute stalled, bit 4 = memory stalled
- flush  in  1  synchronous pipeline flush (exception/eret)
- ex_wd  in  RegAddrBus  destination GPR
- ex_wreg  in  1  GPR write enable
- ex_wdata  in  RegBus  GPR write data
- ex_hi, ex_lo  in  RegBus  HI/LO write data
- ex_whilo  in  1  HI/LO write enable
- ex_aluop  in  AluOpBus  op code, used by memory stage for load/store decode
- ex_mem_addr  in  RegBus  effective address
- ex_reg2  in  RegBus  store data
- hilo_i  in  DoubleRegBus  multiply-accumulate partial product from execute
- cnt_i  in  2  multiply-accumulate cycle count from execute
- mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop, mem_mem_addr, mem_reg2  out  widths as inputs  registered copies
- hilo_o  out  DoubleRegBus  held partial product back to execute
- cnt_o  out  2  held cycle count back to execute

## Operation

All outputs are registers; priority per rising edge, highest first:
- rst=1: every output 0 (`mem_wd`=`NOPRegAddr`=5'b00000, enables `WriteDisable`, `mem_aluop`=`EXE_NOP_OP`=0, `hilo_o`=0, `cnt_o`=0).
- flush=1: same values as reset.
- Bubble (stall[3]=1, stall[4]=0): all `mem_*` outputs take reset values; `hilo_o`←`hilo_i`, `cnt_o`←`cnt_i`.
- Hold (stall[3]=1, stall[4]=1): every output keeps its value, including `hilo_o`/`cnt_o`.
- Capture (stall[3]=0): every `mem_*` ← corresponding `ex_*`; `hilo_o`←0, `cnt_o`←0.
- Stall vector is prefix-monotonic; stall[4]=1 with stall[3]=0 is illegal and resolves to Capture (stall[3] governs).
- No arithmetic; all fields pass bit-exact, no width change.

## Timing

- Latency 1 cycle ex_* → mem_*; throughput 1/cycle when unstalled.
- Flush/reset take effect at the edge where sampled high; outputs valid the following cycle.
- Reset or flush asserted during a multi-cycle stall discards held data and the partial product.
- First unstalled edge after a bubble captures current ex_* inputs; partial product cleared at that same edge.
- No combinational path from any input to any output.

## Configuration

- `MULACC_EN` defined: `hilo_i`/`cnt_i` registered into `hilo_o`/`cnt_o` as above (required for madd/maddu/msub/msubu).
- Not defined: `hilo_o`, `cnt_o` constantly 0, no registers inferred for them; `hilo_i`/`cnt_i` ignored. All other behaviour unchanged.

## Test plan

- Reset: rst=1 for 2 cycles with non-zero inputs → all outputs 0; first edge after release with ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h1234_5678 → same values on mem_* next cycle.
- Bubble: stall=6'b001111, ex_wreg=1, hilo_i=64'hAAAA_0000_0000_5555, cnt_i=1 → mem_wreg=0, mem_wd=0, hilo_o=64'hAAAA_0000_0000_5555, cnt_o=1 (`MULACC_EN` defined); same with macro undefined → hilo_o=0, cnt_o=0.
- Hold: capture ex_wdata=32'hDEAD_BEEF, then stall=6'b011111 for 3 cycles with ex_wdata=32'h0 → mem_wdata stays 32'hDEAD_BEEF each cycle.
- Flush priority: flush=1 with stall=6'b011111 and valid held data → all outputs 0 next cycle.
- Bubble-then-capture: bubble cycle with cnt_i=1, then stall=0, ex_whilo=1, ex_hi=32'h1, ex_lo=32'h2 → mem_whilo=1, mem_hi=1, mem_lo=2, hilo_o=0, cnt_o=0.
- Illegal vector: stall=6'b010000, ex_wd=5'd7 → mem_wd=7 next cycle (Capture).

Source files
------------

// File: rtl/ex_mem.sv
// Execute -> memory-access pipeline register with stall (hold/bubble) and flush handling.
// Optional MULACC_EN carries the multiply-accumulate partial product and cycle count across a stall.
module ex_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,

    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic        ex_whilo,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,

    input  logic [63:0] hilo_i,
    input  logic [1:0]  cnt_i,

    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_whilo,
    output logic [7:0]  mem_aluop,
    output logic [31:0] mem_mem_addr,
    output logic [31:0] mem_reg2,

    output logic [63:0] hilo_o,
    output logic [1:0]  cnt_o
);

    localparam logic [4:0] NOP_REG_ADDR  = 5'b00000;
    localparam logic [7:0] EXE_NOP_OP    = 8'h00;
    localparam logic       WRITE_DISABLE = 1'b0;

    logic        w_clear;
    logic        w_bubble;
    logic        w_capture;

    logic [4:0]  r_wd;
    logic        r_wreg;
    logic [31:0] r_wdata;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_whilo;
    logic [7:0]  r_aluop;
    logic [31:0] r_mem_addr;
    logic [31:0] r_reg2;

    // stall[3] alone decides capture, so the illegal {stall[4]=1, stall[3]=0} captures.
    assign w_clear   = rst | flush;
    assign w_bubble  = stall[3] & ~stall[4];
    assign w_capture = ~stall[3];

    always_ff @(posedge clk) begin
        if (w_clear || w_bubble) begin
            r_wd       <= NOP_REG_ADDR;
            r_wreg     <= WRITE_DISABLE;
            r_wdata    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_whilo    <= WRITE_DISABLE;
            r_aluop    <= EXE_NOP_OP;
            r_mem_addr <= '0;
            r_reg2     <= '0;
        end else if (w_capture) begin
            r_wd       <= ex_wd;
            r_wreg     <= ex_wreg;
            r_wdata    <= ex_wdata;
            r_hi       <= ex_hi;
            r_lo       <= ex_lo;
            r_whilo    <= ex_whilo;
            r_aluop    <= ex_aluop;
            r_mem_addr <= ex_mem_addr;
            r_reg2     <= ex_reg2;
        end
    end

    assign mem_wd       = r_wd;
    assign mem_wreg     = r_wreg;
    assign mem_wdata    = r_wdata;
    assign mem_hi       = r_hi;
    assign mem_lo       = r_lo;
    assign mem_whilo    = r_whilo;
    assign mem_aluop    = r_aluop;
    assign mem_mem_addr = r_mem_addr;
    assign mem_reg2     = r_reg2;

`ifdef MULACC_EN
    logic [63:0] r_hilo;
    logic [1:0]  r_cnt;
    logic        w_unused;

    // Partial product survives only a bubble; a capture means the MAC completed.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_hilo <= '0;
            r_cnt  <= '0;
        end else if (w_bubble) begin
            r_hilo <= hilo_i;
            r_cnt  <= cnt_i;
        end else if (w_capture) begin
            r_hilo <= '0;
            r_cnt  <= '0;
        end
    end

    assign hilo_o   = r_hilo;
    assign cnt_o    = r_cnt;
    assign w_unused = ^{stall[5], stall[2:0]};
`else
    logic w_unused;

    assign hilo_o   = '0;
    assign cnt_o    = '0;
    assign w_unused = ^{stall[5], stall[2:0], hilo_i, cnt_i};
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Bench for ex_mem: vector table plus a random capture burst, checked through an expected-value queue.
module tb_ex_mem;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [31:0] reg2;
    } fields_t;

    typedef struct {
        string       name;
        logic        rst;
        logic        flush;
        logic [5:0]  stall;
        fields_t     ex;
        logic [63:0] hilo_i;
        logic [1:0]  cnt_i;
        fields_t     exp_f;
        logic [63:0] exp_hilo;
        logic [1:0]  exp_cnt;
    } vec_t;

    typedef struct {
        string       name;
        fields_t     f;
        logic [63:0] h;
        logic [1:0]  c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic        ex_whilo;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_reg2;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_whilo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int n_chk  = 0;
    int n_pass = 0;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    ex_mem dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    function automatic fields_t fld(logic [4:0] wd, logic wreg, logic [31:0] wdata,
                                    logic whilo, logic [31:0] hi, logic [31:0] lo,
                                    logic [7:0] aluop, logic [31:0] addr, logic [31:0] reg2);
        fields_t f;
        f.wd = wd; f.wreg = wreg; f.wdata = wdata; f.whilo = whilo;
        f.hi = hi; f.lo = lo; f.aluop = aluop; f.addr = addr; f.reg2 = reg2;
        return f;
    endfunction

    task automatic add(string name, logic r, logic fl, logic [5:0] st, fields_t ex,
                       logic [63:0] hi_in, logic [1:0] c_in,
                       fields_t ef, logic [63:0] eh, logic [1:0] ec);
        vec_t v;
        v.name = name; v.rst = r; v.flush = fl; v.stall = st; v.ex = ex;
        v.hilo_i = hi_in; v.cnt_i = c_in; v.exp_f = ef; v.exp_hilo = eh; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    // Drive one cycle of stimulus at the falling edge and queue what the next rising edge must produce.
    task automatic drive(vec_t v);
        exp_t e;
        @(negedge clk);
        rst = v.rst; flush = v.flush; stall = v.stall;
        ex_wd = v.ex.wd; ex_wreg = v.ex.wreg; ex_wdata = v.ex.wdata;
        ex_whilo = v.ex.whilo; ex_hi = v.ex.hi; ex_lo = v.ex.lo;
        ex_aluop = v.ex.aluop; ex_mem_addr = v.ex.addr; ex_reg2 = v.ex.reg2;
        hilo_i = v.hilo_i; cnt_i = v.cnt_i;
        e.name = v.name;
        e.f = v.exp_f;
`ifdef MULACC_EN
        e.h = v.exp_hilo;
        e.c = v.exp_cnt;
`else
        e.h = '0;
        e.c = '0;
`endif
        sb.push_back(e);
    endtask

    task automatic check_cycle();
        exp_t    e;
        fields_t got;
        @(posedge clk);
        #1;
        got = fld(mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
                  mem_aluop, mem_mem_addr, mem_reg2);
        n_chk++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: got output with no expected entry");
            n_chk++;
            return;
        end
        e = sb.pop_front();
        if (got !== e.f)
            $display("FAIL %s mem_fields: got %h exp %h", e.name, got, e.f);
        else
            n_pass++;
        n_chk++;
        if (hilo_o !== e.h || cnt_o !== e.c)
            $display("FAIL %s hilo/cnt: got %h/%0d exp %h/%0d", e.name, hilo_o, cnt_o, e.h, e.c);
        else
            n_pass++;
    endtask

    initial begin
        fields_t z, a, r, b, hl, d, i7;
        logic [63:0] h1, h2;

        rst = 1'b1; flush = 1'b0; stall = '0;
        ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_hi = '0; ex_lo = '0;
        ex_whilo = 1'b0; ex_aluop = '0; ex_mem_addr = '0; ex_reg2 = '0;
        hilo_i = '0; cnt_i = '0;

        z  = '0;
        a  = fld(5'd9,  1'b1, 32'hCAFE_F00D, 1'b1, 32'h1111_2222, 32'h3333_4444, 8'h23, 32'h0000_1000, 32'h5555_6666);
        r  = fld(5'd3,  1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0);
        b  = fld(5'd2,  1'b1, 32'h0BAD_0001, 1'b0, 32'h0, 32'h0, 8'h24, 32'h0000_0040, 32'h0000_0077);
        hl = fld(5'd0,  1'b0, 32'h0,         1'b1, 32'h1, 32'h2, 8'h00, 32'h0, 32'h0);
        d  = fld(5'd12, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 8'h2B, 32'h0000_0080, 32'hFEED_0001);
        i7 = fld(5'd7,  1'b1, 32'h0000_7777, 1'b0, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0);
        h1 = 64'hAAAA_0000_0000_5555;
        h2 = 64'h0123_4567_89AB_CDEF;

        //   name            rst   fl    stall      ex  hilo_i cnt  exp_f exp_h exp_c
        add("rst0",          1'b1, 1'b0, 6'b000000, a,  h2, 2'd3, z,  64'h0, 2'd0);
        add("rst1",          1'b1, 1'b0, 6'b011111, a,  h2, 2'd3, z,  64'h0, 2'd0);
        add("cap_after_rst", 1'b0, 1'b0, 6'b000000, r,  h2, 2'd3, r,  64'h0, 2'd0);
        add("bubble",        1'b0, 1'b0, 6'b001111, b,  h1, 2'd1, z,  h1,    2'd1);
        add("bubble_to_cap", 1'b0, 1'b0, 6'b000000, hl, h2, 2'd2, hl, 64'h0, 2'd0);
        add("cap_dead",      1'b0, 1'b0, 6'b000000, d,  h2, 2'd3, d,  64'h0, 2'd0);
        add("hold1",         1'b0, 1'b0, 6'b011111, z,  h1, 2'd1, d,  64'h0, 2'd0);
        add("hold2",         1'b0, 1'b0, 6'b011111, z,  h1, 2'd1, d,  64'h0, 2'd0);
        add("hold3",         1'b0, 1'b0, 6'b011111, z,  h1, 2'd1, d,  64'h0, 2'd0);
        add("flush_in_hold", 1'b0, 1'b1, 6'b011111, a,  h1, 2'd1, z,  64'h0, 2'd0);
        add("illegal_stall", 1'b0, 1'b0, 6'b010000, i7, h1, 2'd2, i7, 64'h0, 2'd0);
        add("bubble2",       1'b0, 1'b0, 6'b001111, a,  h2, 2'd2, z,  h2,    2'd2);
        add("hold_hilo1",    1'b0, 1'b0, 6'b111111, b,  h1, 2'd1, z,  h2,    2'd2);
        add("hold_hilo2",    1'b0, 1'b0, 6'b011111, b,  h1, 2'd3, z,  h2,    2'd2);
        add("rst_in_stall",  1'b1, 1'b0, 6'b111111, a,  h1, 2'd1, z,  64'h0, 2'd0);
        add("bubble3",       1'b0, 1'b0, 6'b001111, a,  h1, 2'd3, z,  h1,    2'd3);
        add("flush_bubble",  1'b0, 1'b1, 6'b001111, a,  h2, 2'd2, z,  64'h0, 2'd0);
        add("cap_a",         1'b0, 1'b0, 6'b000000, a,  h1, 2'd1, a,  64'h0, 2'd0);
        add("cap_b",         1'b0, 1'b0, 6'b000000, b,  h2, 2'd2, b,  64'h0, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            check_cycle();
        end

        // Back-to-back random captures: one result per cycle, one cycle late.
        for (int i = 0; i < 8; i++) begin
            fields_t rf;
            rf = fld(5'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom, $urandom,
                     8'($urandom), $urandom, $urandom);
            add($sformatf("burst%0d", i), 1'b0, 1'b0, 6'b000000, rf,
                {$urandom, $urandom}, 2'($urandom), rf, 64'h0, 2'd0);
            drive(vecs[vecs.size() - 1]);
            check_cycle();
        end

        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_leftover: got %0d entries exp 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
